// File: rtl/battle_pkg.sv
// Shared types and helpers for the party battle controller and related menu FSMs.
package battle_pkg;

    typedef enum logic [3:0] {
        S_LOAD,
        S_ORDER,
        S_CALC_A,
        S_APPLY_A,
        S_CHECK_A,
        S_CALC_B,
        S_APPLY_B,
        S_CHECK_B,
        S_SWITCH,
        S_END_TURN,
        S_VICTORY,
        S_LOSS,
        S_DRAW
    } state_t;

    localparam logic TRAINER_PLAYER = 1'b0;
    localparam logic TRAINER_AI     = 1'b1;

    // Width of a party slot index; a one-Pokemon party still needs a 1-bit index.
    function automatic int slot_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/battle_control_party_if.sv
// Control/status bundle between the battle sequencer and the go button / HP datapath.
interface battle_control_party_if
    import battle_pkg::*;
#(
    parameter int PARTY_SIZE = 3,
    parameter int SPD_W      = 8,
    parameter int TURN_W     = 8
);
    localparam int SLOT_W = slot_w(PARTY_SIZE);

    logic              go;
    logic [SPD_W-1:0]  p_speed;
    logic [SPD_W-1:0]  ai_speed;
    logic              p_hp_zero;
    logic              ai_hp_zero;
    logic              calc_damage;
    logic              apply_damage;
    logic              active_trainer;
    logic              target;
    logic              load_slot;
    logic [SLOT_W-1:0] p_slot;
    logic [SLOT_W-1:0] ai_slot;
    logic [TURN_W-1:0] turn_count;
    logic              victory;
    logic              loss;
    logic              draw;

    modport master (
        output go, p_speed, ai_speed, p_hp_zero, ai_hp_zero,
        input  calc_damage, apply_damage, active_trainer, target, load_slot,
               p_slot, ai_slot, turn_count, victory, loss, draw
    );

    modport slave (
        input  go, p_speed, ai_speed, p_hp_zero, ai_hp_zero,
        output calc_damage, apply_damage, active_trainer, target, load_slot,
               p_slot, ai_slot, turn_count, victory, loss, draw
    );

endinterface

// File: rtl/go_edge_detect.sv
// Rising-edge detector: a level held high yields a single one-cycle pulse.
module go_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);
    logic d_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) d_reg <= 1'b0;
        else       d_reg <= d;
    end

    assign pulse = d & ~d_reg;

endmodule

// File: rtl/battle_control_party.sv
// Turn sequencer for player vs AI parties: speed ordering, faint checks,
// automatic switch-in of the next slot, turn counting and battle result.
module battle_control_party
    import battle_pkg::*;
#(
    parameter int PARTY_SIZE = 3,
    parameter int SPD_W      = 8,
    parameter int TURN_W     = 8,
    parameter int MAX_TURNS  = 100
) (
    input  logic clk,
    input  logic reset,
    battle_control_party_if.slave bus
);
    localparam int                SLOT_W     = slot_w(PARTY_SIZE);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(PARTY_SIZE - 1);
    localparam logic [TURN_W-1:0] TURN_LIMIT = TURN_W'(MAX_TURNS);

    state_t            state_reg, state_next;
    logic [SLOT_W-1:0] p_slot_reg, p_slot_next;
    logic [SLOT_W-1:0] ai_slot_reg, ai_slot_next;
    logic [TURN_W-1:0] turn_reg, turn_next;
    logic              first_reg, first_next;
    logic              go_pulse;
    logic              tgt_ai, tgt_zero, tgt_last;
    logic [SPD_W-1:0]  p_spd, ai_spd;

    assign p_spd  = bus.p_speed;
    assign ai_spd = bus.ai_speed;

    go_edge_detect u_go_edge (
        .clk   (clk),
        .reset (reset),
        .d     (bus.go),
        .pulse (go_pulse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_LOAD;
            p_slot_reg  <= '0;
            ai_slot_reg <= '0;
            turn_reg    <= '0;
            first_reg   <= TRAINER_PLAYER;
        end else begin
            state_reg   <= state_next;
            p_slot_reg  <= p_slot_next;
            ai_slot_reg <= ai_slot_next;
            turn_reg    <= turn_next;
            first_reg   <= first_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        p_slot_next  = p_slot_reg;
        ai_slot_next = ai_slot_reg;
        turn_next    = turn_reg;
        first_next   = first_reg;
        tgt_ai       = 1'b0;
        tgt_zero     = 1'b0;
        tgt_last     = 1'b0;
        case (state_reg)
            S_LOAD:    if (go_pulse) state_next = S_ORDER;
            // Speed tie goes to the player.
            S_ORDER: begin
                first_next = (ai_spd > p_spd) ? TRAINER_AI : TRAINER_PLAYER;
                state_next = S_CALC_A;
            end
            S_CALC_A:  if (go_pulse) state_next = S_APPLY_A;
            S_APPLY_A: if (go_pulse) state_next = S_CHECK_A;
            S_CALC_B:  if (go_pulse) state_next = S_APPLY_B;
            S_APPLY_B: if (go_pulse) state_next = S_CHECK_B;
            // Only the defender of the current half-turn is examined for a faint.
            S_CHECK_A, S_CHECK_B: begin
                tgt_ai   = (state_reg == S_CHECK_A) ? ~first_reg : first_reg;
                tgt_zero = tgt_ai ? bus.ai_hp_zero : bus.p_hp_zero;
                tgt_last = tgt_ai ? (ai_slot_reg == LAST_SLOT) : (p_slot_reg == LAST_SLOT);
                if (!tgt_zero) begin
                    state_next = (state_reg == S_CHECK_A) ? S_CALC_B : S_END_TURN;
                end else if (tgt_last) begin
                    state_next = tgt_ai ? S_VICTORY : S_LOSS;
                end else begin
                    if (tgt_ai) ai_slot_next = ai_slot_reg + SLOT_W'(1);
                    else        p_slot_next  = p_slot_reg + SLOT_W'(1);
                    state_next = S_SWITCH;
                end
            end
            S_SWITCH:  state_next = S_END_TURN;
            S_END_TURN: begin
                if (turn_reg != '1) turn_next = turn_reg + TURN_W'(1);
                state_next = (MAX_TURNS != 0 && turn_next == TURN_LIMIT) ? S_DRAW : S_LOAD;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.calc_damage    = 1'b0;
        bus.apply_damage   = 1'b0;
        bus.active_trainer = 1'b0;
        bus.target         = 1'b0;
        bus.load_slot      = 1'b0;
        bus.victory        = 1'b0;
        bus.loss           = 1'b0;
        bus.draw           = 1'b0;
        case (state_reg)
            S_CALC_A: begin
                bus.calc_damage    = 1'b1;
                bus.active_trainer = first_reg;
                bus.target         = ~first_reg;
            end
            S_APPLY_A: begin
                bus.apply_damage = 1'b1;
                bus.target       = ~first_reg;
            end
            S_CALC_B: begin
                bus.calc_damage    = 1'b1;
                bus.active_trainer = ~first_reg;
                bus.target         = first_reg;
            end
            S_APPLY_B: begin
                bus.apply_damage = 1'b1;
                bus.target       = first_reg;
            end
            S_SWITCH:  bus.load_slot = 1'b1;
            S_VICTORY: bus.victory   = 1'b1;
            S_LOSS:    bus.loss      = 1'b1;
            S_DRAW:    bus.draw      = 1'b1;
            default: ;
        endcase
    end

    assign bus.p_slot     = p_slot_reg;
    assign bus.ai_slot    = ai_slot_reg;
    assign bus.turn_count = turn_reg;

endmodule

// File: doc/battle_control_party.md
Name: battle_control_party

Overview:
Parametrised successor to the single-Pokemon battle controller. It sequences full turns between player and AI parties of PARTY_SIZE Pokemon each, with speed-based attack order, faint detection, and automatic switch-in of the next party slot. It also counts turns and ends the battle as a victory, loss or draw. It sits between the top-level go button and the damage/HP datapath, driving the same calc/apply/target/active_trainer controls plus slot-select and result outputs.

Parameters:
PARTY_SIZE, 3, Pokemon per party (>=1); SLOT_W = max(1, clog2(PARTY_SIZE)) is a derived localparam
SPD_W, 8, width of speed stat inputs
TURN_W, 8, width of turn counter
MAX_TURNS, 100, turn limit for draw; 0 disables the draw condition

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
go  in  1  step request (level input; internally rising-edge detected)
p_speed  in  SPD_W  active player Pokemon speed
ai_speed  in  SPD_W  active AI Pokemon speed
p_hp_zero  in  1  datapath flag: player active HP == 0
ai_hp_zero  in  1  datapath flag: AI active HP == 0
calc_damage  out  1  datapath computes damage
apply_damage  out  1  datapath subtracts damage from target
active_trainer  out  1  0 = player attacking, 1 = AI attacking
target  out  1  0 = player Pokemon, 1 = AI Pokemon
load_slot  out  1  one-cycle pulse: datapath loads the Pokemon in p_slot/ai_slot
p_slot  out  SLOT_W  player active party index
ai_slot  out  SLOT_W  AI active party index
turn_count  out  TURN_W  completed turns
victory  out  1  sticky: AI party wiped
loss  out  1  sticky: player party wiped
draw  out  1  sticky: turn limit reached

Behaviour:
- Reset (async, active-high): state=S_LOAD, slots=0, turn_count=0, first=0, go edge register=0. All outputs 0.
- go_pulse = go & ~go_q; go_q is registered each cycle. A held go advances exactly one step.
- States and transitions:
  - S_LOAD: go_pulse -> S_ORDER.
  - S_ORDER (1 cycle): register first = (ai_speed > p_speed). A tie gives the player first attack. -> S_CALC_A.
  - S_CALC_A: calc_damage=1; active_trainer=first; target=~first. go_pulse -> S_APPLY_A.
  - S_APPLY_A: apply_damage=1; target=~first. go_pulse -> S_CHECK_A.
  - S_CHECK_A (1 cycle): samples the hp_zero flag of target ~first.
    - Flag clear -> S_CALC_B.
    - Flag set, target's slot == PARTY_SIZE-1 -> S_VICTORY if target is AI, else S_LOSS.
    - Flag set, otherwise -> increment target's slot, then S_SWITCH. The fainted Pokemon loses its attack this turn.
  - S_CALC_B / S_APPLY_B / S_CHECK_B: mirror of the A states with roles swapped (active_trainer=~first, target=first). No faint in S_CHECK_B -> S_END_TURN.
  - S_SWITCH (1 cycle): load_slot=1 -> S_END_TURN.
  - S_END_TURN (1 cycle): turn_count += 1 (saturates at all-ones). If MAX_TURNS!=0 and the new count == MAX_TURNS -> S_DRAW, else -> S_LOAD.
  - S_VICTORY / S_LOSS / S_DRAW: terminal; drive victory/loss/draw=1; ignore go; hold until reset.
- Faint check has priority over turn limit: a knockout on the final turn yields victory/loss, not draw.
- Both hp_zero flags set in S_CHECK_A: only the current target's flag is considered.
- Control outputs are Moore-decoded from state. Slots, turn_count and first are registers.
- Reset asserted mid-turn returns the FSM to S_LOAD on the next evaluation, with no output glitch beyond the reset edge.

Decomposition:
- Package battle_pkg: state enum; TRAINER_PLAYER=0 / TRAINER_AI=1 constants; SLOT_W function.
- Sub-module go_edge_detect (1-bit rising-edge detector with async reset), reusable by other menu FSMs.

Test Plan:
- PARTY_SIZE=1, p_speed=50, ai_speed=40, ai_hp_zero set in CHECK_A -> player attacks first (active_trainer=0, target=1), victory=1 after 3 go pulses + 1 cycle, turn_count=0.
- p_speed=30, ai_speed=30 (tie) -> first=0; in S_CALC_A active_trainer=0.
- ai_speed=90 > p_speed=10, PARTY_SIZE=3, p_hp_zero set in CHECK_A -> p_slot 0->1, load_slot one-cycle pulse, S_CALC_B skipped, turn_count=1, back to S_LOAD.
- go held high for 20 cycles from S_LOAD -> only S_LOAD->S_ORDER->S_CALC_A, no further advance.
- MAX_TURNS=2, no faints -> draw=1 after second S_END_TURN; turn_count=2; later go pulses leave outputs unchanged.
- Reset asserted in S_APPLY_B with ai_slot=2 -> all outputs 0, slots 0, state S_LOAD immediately (asynchronous).
